// File: rtl/encrypter_core.sv
// encrypter_core: frames a plaintext message with preamble bytes, XORs every
// framed byte with a 5-bit LFSR keystream and writes MSG_LEN ciphertext bytes
// starting at CT_BASE.
//
// Memory timing: mem_raddr is registered and presented during READ. The memory
// returns that byte one cycle later, which is during WRITE. At the end of each
// PAD/WRITE cycle the write strobe, address and data registers are loaded, so
// the strobe is visible in the cycle that follows that state.
module encrypter_core #(
  parameter int ADDR_W  = 8,
  parameter int PT_BASE = 128,
  parameter int CT_BASE = 0,
  parameter int MSG_LEN = 64,
  parameter int MAX_MSG = 50
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic [7:0]        preamble,
  input  logic [7:0]        pre_len,
  input  logic [7:0]        msg_len,
  input  logic [4:0]        lfsr_taps,
  input  logic [4:0]        lfsr_init,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IW = $clog2(MSG_LEN) + 1;
  localparam logic [ADDR_W-1:0] PT_A    = ADDR_W'(PT_BASE);
  localparam logic [ADDR_W-1:0] CT_A    = ADDR_W'(CT_BASE);
  localparam logic [7:0]        MAX_B   = 8'(MAX_MSG);
  localparam logic [IW-1:0]     LAST_IX = IW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAD, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [4:0]      lfsr_reg;
  logic [4:0]      taps_reg;
  logic [7:0]      pre_byte_reg;
  logic [7:0]      pre_cnt_reg;
  logic [7:0]      msg_cnt_reg;

  logic [7:0]        pre_eff, msg_eff;
  logic [4:0]        seed_eff;
  logic              clamp_err;
  logic [IW-1:0]     idx_next;
  logic [8:0]        idx_next9, msg_end9;
  logic              next_is_msg;
  logic [ADDR_W-1:0] next_raddr;
  logic [4:0]        lfsr_next;
  logic [7:0]        key_byte;

  // Configuration clamps applied to the live inputs when LOAD latches them.
  always_comb begin
    pre_eff   = pre_len;
    msg_eff   = msg_len;
    seed_eff  = lfsr_init;
    clamp_err = 1'b0;
    if (pre_len < 8'd7) begin
      pre_eff   = 8'd7;
      clamp_err = 1'b1;
    end else if (pre_len > 8'd12) begin
      pre_eff   = 8'd12;
      clamp_err = 1'b1;
    end
    if (msg_len > MAX_B) begin
      msg_eff   = MAX_B;
      clamp_err = 1'b1;
    end
    if (lfsr_init == 5'd0) begin
      seed_eff  = 5'h01;
      clamp_err = 1'b1;
    end
  end

  // Framing lookahead for the byte after the current one, and keystream step.
  always_comb begin
    idx_next    = idx_reg + 1'b1;
    idx_next9   = 9'(idx_next);
    msg_end9    = {1'b0, pre_cnt_reg} + {1'b0, msg_cnt_reg};
    next_is_msg = (idx_next9 >= {1'b0, pre_cnt_reg}) && (idx_next9 < msg_end9);
    next_raddr  = PT_A + ADDR_W'(idx_next) - ADDR_W'(pre_cnt_reg);
    lfsr_next   = {lfsr_reg[3:0], ^(lfsr_reg & taps_reg)};
    key_byte    = {3'b000, lfsr_reg};
  end

  // Control FSM with registered memory-side and status outputs.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      lfsr_reg     <= 5'h01;
      taps_reg     <= '0;
      pre_byte_reg <= '0;
      pre_cnt_reg  <= '0;
      msg_cnt_reg  <= '0;
      mem_raddr    <= '0;
      mem_wr_en    <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg <= S_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_LOAD: begin
          pre_byte_reg <= preamble;
          pre_cnt_reg  <= pre_eff;
          msg_cnt_reg  <= msg_eff;
          taps_reg     <= lfsr_taps;
          lfsr_reg     <= seed_eff;
          cfg_err      <= clamp_err;
          idx_reg      <= '0;
          // pre_len is at least 7 after clamping, so byte 0 is always padding.
          state_reg    <= S_PAD;
        end
        S_READ: begin
          state_reg <= S_WRITE;
        end
        S_PAD, S_WRITE: begin
          mem_wr_en <= 1'b1;
          mem_waddr <= CT_A + ADDR_W'(idx_reg);
          mem_wdata <= ((state_reg == S_PAD) ? pre_byte_reg : mem_rdata) ^ key_byte;
          lfsr_reg  <= lfsr_next;
          idx_reg   <= idx_next;
          if (idx_reg == LAST_IX) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (next_is_msg) begin
            state_reg <= S_READ;
            mem_raddr <= next_raddr;
          end else begin
            state_reg <= S_PAD;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypter_core.sv
// Scoreboard testbench for encrypter_core: a reference model computes the
// expected ciphertext writes per run, a monitor pops and compares each write.
module tb_encrypter_core;

  localparam int ADDR_W  = 8;
  localparam int PT_BASE = 128;
  localparam int CT_BASE = 0;
  localparam int MSG_LEN = 64;
  localparam int MAX_MSG = 50;

  logic              clk = 1'b0;
  logic              init_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        preamble = '0;
  logic [7:0]        pre_len = '0;
  logic [7:0]        msg_len = '0;
  logic [4:0]        lfsr_taps = '0;
  logic [4:0]        lfsr_init = '0;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata = '0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              busy, done, cfg_err;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  logic [7:0]  pt_mem [0:255];
  logic [7:0]  ct_mem [0:255];
  logic [15:0] exp_q [$];

  encrypter_core #(
    .ADDR_W(ADDR_W), .PT_BASE(PT_BASE), .CT_BASE(CT_BASE),
    .MSG_LEN(MSG_LEN), .MAX_MSG(MAX_MSG)
  ) dut (
    .clk(clk), .init_n(init_n), .start(start), .preamble(preamble),
    .pre_len(pre_len), .msg_len(msg_len), .lfsr_taps(lfsr_taps),
    .lfsr_init(lfsr_init), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Memory: registered read one cycle after address, writes on strobe.
  always @(posedge clk) begin
    mem_rdata <= pt_mem[mem_raddr];
    if (mem_wr_en) ct_mem[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues is matched against the scoreboard.
  always @(negedge clk) begin
    if (init_n && mem_wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h", mem_waddr, mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        $display("write addr %02h data %02h expect %02h %02h", mem_waddr, mem_wdata, e[15:8], e[7:0]);
        chk("wr_addr", int'(mem_waddr), int'(e[15:8]));
        chk("wr_data", int'(mem_wdata), int'(e[7:0]));
      end
    end
  end

  // Reference: framed byte stream XOR keystream, using clamped config.
  task automatic build_expected(input int pre, input int ml, input logic [4:0] tp,
                                input logic [4:0] sd, input logic [7:0] pa,
                                output int lat, output int err);
    int pe, me;
    logic [4:0] l;
    logic [7:0] b;
    pe  = (pre < 7) ? 7 : (pre > 12) ? 12 : pre;
    me  = (ml > MAX_MSG) ? MAX_MSG : ml;
    l   = (sd == 0) ? 5'h01 : sd;
    err = (pe != pre || me != ml || sd == 0) ? 1 : 0;
    lat = 1 + MSG_LEN + me;
    exp_q.delete();
    for (int i = 0; i < MSG_LEN; i++) begin
      if (i >= pe && i < pe + me) b = pt_mem[(PT_BASE + i - pe) % 256];
      else b = pa;
      exp_q.push_back({8'((CT_BASE + i) % 256), b ^ {3'b000, l}});
      l = {l[3:0], ^(l & tp)};
    end
  endtask

  task automatic run_case(input int pre, input int ml, input logic [4:0] tp,
                          input logic [4:0] sd, input logic [7:0] pa,
                          input bit glitch, input bit abort_run);
    int lat, err, cnt;
    bit got;
    pre_len = 8'(pre); msg_len = 8'(ml); lfsr_taps = tp; lfsr_init = sd; preamble = pa;
    build_expected(pre, ml, tp, sd, pa, lat, err);
    wr_seen = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0; got = 0;
    while (cnt < 300 && !got) begin
      @(posedge clk); #1 cnt++;
      if (glitch && cnt == 30) start = 1'b1;
      if (glitch && cnt == 31) start = 1'b0;
      if (abort_run && wr_seen >= 20) begin
        init_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_en", int'(mem_wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk); init_n = 1'b1;
        exp_q.delete();
        $display("run aborted pre=%0d ml=%0d after %0d writes", pre, ml, wr_seen);
        return;
      end
      if (done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done after %0d cycles, required %0d", cnt, lat);
      return;
    end
    $display("run pre=%0d ml=%0d taps=%02h seed=%02h pa=%02h latency=%0d cfg_err=%0d",
             pre, ml, tp, sd, pa, cnt, cfg_err);
    chk("latency", cnt, lat);
    chk("cfg_err", int'(cfg_err), err);
    chk("busy_at_done", int'(busy), 0);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    string s;
    logic [4:0] tap_tab [0:5];
    logic [4:0] seed_tab [0:2];
    s = "Hey_Hamm_Look_Im_Picasso";
    tap_tab  = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};
    seed_tab = '{5'h01, 5'h00, 5'h15};
    for (int a = 0; a < 256; a++) begin pt_mem[a] = 8'($urandom); ct_mem[a] = '0; end

    // Reset state
    init_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_raddr", int'(mem_raddr), 0);
    chk("rst_waddr", int'(mem_waddr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    @(negedge clk); init_n = 1'b1;

    // T1: all-preamble frame
    run_case(9, 0, 5'h1B, 5'h01, 8'h7E, 0, 0);
    chk("t1_ct0", int'(ct_mem[0]), 8'h7F);
    chk("t1_ct1", int'(ct_mem[1]), 8'h7D);
    chk("t1_ct2", int'(ct_mem[2]), 8'h78);
    chk("t1_ct3", int'(ct_mem[3]), 8'h73);
    chk("t1_done_level", int'(done), 1);

    // T2: text message
    for (int j = 0; j < s.len(); j++) pt_mem[PT_BASE + j] = s[j];
    run_case(9, 24, 5'h1B, 5'h01, 8'h7E, 0, 0);
    chk("t2_ct9", int'(ct_mem[9]), 8'h5A);

    // T3: every clamp active
    run_case(3, 60, 5'h1B, 5'h00, 8'hA5, 0, 0);
    run_case(200, 255, 5'h14, 5'h07, 8'h3C, 0, 0);

    // T4: abort mid-run, then a fresh run
    run_case(10, 30, 5'h17, 5'h09, 8'h55, 0, 1);
    run_case(10, 30, 5'h17, 5'h09, 8'h55, 0, 0);

    // T5: start while busy; start together with reset
    run_case(8, 40, 5'h1D, 5'h1F, 8'hC3, 1, 0);
    @(negedge clk); init_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy", int'(busy), 0);
    @(negedge clk); init_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_idle", int'(busy), 0);
    chk("rst_start_done", int'(done), 0);

    // T6: sweep taps x seeds x pre_len with random messages
    for (int t = 0; t < 6; t++)
      for (int k = 0; k < 3; k++)
        for (int p = 7; p <= 12; p++) begin
          for (int a = PT_BASE; a < PT_BASE + MAX_MSG; a++) pt_mem[a] = 8'($urandom);
          run_case(p, int'($urandom_range(0, 50)), tap_tab[t], seed_tab[k],
                   8'($urandom), 0, 0);
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
